mem_request_sequencer: RTL and testbench

Upstream request stage for the processor's cached memory subsystem. Accepts load/store requests (direct or indirect) from the processor control path and buffers them in a small FIFO. Issues them one at a time to the memory module's `cntrl`/`addr`/`dataIn`/`isIndirect` port, holding each until `dataReady`, then returns the read data or completion to the requester. Provides pipeline back-pressure and a watchdog timeout so a hung cache/RAM handshake cannot stall the processor forever.

---
 rtl/mem_seq_pkg.sv | 35 +++
 rtl/mem_request_sequencer_req_fifo.sv | 81 ++++++++
 rtl/mem_request_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mem_request_sequencer.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Package     : mem_seq_pkg
// Description : Constants shared by the memory request sequencer, the memory
//               module and the cache controller: memory operation codes and
//               the sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

    // Memory-side operation codes (2'b11 is reserved and never driven)
    localparam logic [1:0] CNTRL_IDLE  = 2'b00;
    localparam logic [1:0] CNTRL_READ  = 2'b01;
    localparam logic [1:0] CNTRL_WRITE = 2'b10;

    // Sequencer FSM state encoding
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RESP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;

    // Width of the WAIT watchdog counter; covers timeoutCycles up to 2^16-1
    localparam int unsigned TMO_CNT_W = 16;

    // Map a request direction onto the memory operation code
    function automatic logic [1:0] op_code(input logic is_write);
        return is_write ? CNTRL_WRITE : CNTRL_READ;
    endfunction

endpackage : mem_seq_pkg

`default_nettype wire

// File: rtl/mem_request_sequencer_req_fifo.sv
// ============================================================================
// Module      : req_fifo
// Description : Small synchronous request FIFO for the memory request
//               sequencer. Power-of-two depth, occupancy counter, full/empty
//               flags and a show-ahead head entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clrN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    // DEPTH is at least 2, so the pointer width is at least one bit
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full is taken from the registered occupancy, so a pop in the same
    // cycle never frees a slot for a simultaneous push.
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = storage_q[rd_ptr_q];

    // Next occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: it is only read when the count says valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : req_fifo

`default_nettype wire

// File: rtl/mem_request_sequencer.sv
// ============================================================================
// Module      : mem_request_sequencer
// Description : Upstream request stage of the cached memory subsystem.
//               Buffers load/store requests, issues them one at a time to the
//               memory module, waits for dataReady (with a watchdog abort),
//               returns a one-cycle response and drains the ready handshake
//               before the next issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_request_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int fifoDepth     = 2,
    parameter int timeoutCycles = 255
) (
    input  logic                clk,
    input  logic                clrN,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqWrite,
    input  logic                reqIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] reqData,
    output logic                rspValid,
    output logic [ramWidth-1:0] rspData,
    output logic                rspError,
    output logic                busy,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIsIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady
);

    // FIFO entry layout: {write, indirect, addr, data}
    localparam int ENTRY_W = 2 + addrSize + ramWidth;
    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(timeoutCycles);

    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [STATE_W-1:0]   state_q;
    logic [STATE_W-1:0]   state_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q;
    logic [TMO_CNT_W-1:0] tmo_cnt_d;
    logic [ramWidth-1:0]  rsp_data_q;
    logic [ramWidth-1:0]  rsp_data_d;
    logic                 rsp_err_q;
    logic                 rsp_err_d;

    logic                 issue_write_q;
    logic                 issue_ind_q;
    logic [addrSize-1:0]  issue_addr_q;
    logic [ramWidth-1:0]  issue_data_q;

    // ------------------------------------------------------------------
    // Request buffering
    // ------------------------------------------------------------------
    assign fifo_wdata = {reqWrite, reqIndirect, reqAddr, reqData};
    assign fifo_push  = reqValid && !fifo_full;
    assign reqReady   = !fifo_full;

    // The head is only consumed from IDLE, one request in flight at a time
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (fifoDepth)
    ) u_req_fifo (
        .clk         (clk),
        .clrN        (clrN),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // Next-state, watchdog and response capture logic
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                // Completion takes priority over a watchdog expiry in the
                // same cycle, and a ready already high on entry counts.
                if (memDataReady) begin
                    rsp_data_d = memDataOut;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Hold off the next issue until the memory drops its ready
                if (!memDataReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, watchdog and response registers
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Issue register: loaded only on the pop out of IDLE, so the memory
    // outputs it feeds cannot move during ISSUE or WAIT.
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            issue_write_q <= 1'b0;
            issue_ind_q   <= 1'b0;
            issue_addr_q  <= '0;
            issue_data_q  <= '0;
        end else if (fifo_pop) begin
            {issue_write_q, issue_ind_q, issue_addr_q, issue_data_q} <= fifo_head;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // memCntrl decodes straight from the state register so that an
    // asynchronous reset drops it to idle without waiting for a clock.
    assign memCntrl      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ?
                           op_code(issue_write_q) : CNTRL_IDLE;
    assign memAddr       = issue_addr_q;
    assign memDataIn     = issue_data_q;
    assign memIsIndirect = issue_ind_q;

    assign rspValid      = (state_q == ST_RESP);
    assign rspData       = rsp_data_q;
    assign rspError      = rsp_err_q && (state_q == ST_RESP);
    assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule : mem_request_sequencer

`default_nettype wire

// File: tb/tb_mem_request_sequencer.sv
// ============================================================================
// Module      : tb_mem_request_sequencer
// Description : Self-checking bench for mem_request_sequencer. A transaction
//               level reference model (request queues, issue/response cycle
//               rules and a scripted memory) predicts every output per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_request_sequencer;

    localparam int RW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 2;
    localparam int TMO   = 4;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          clrN;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic          reqIndirect;
    logic [AW-1:0] reqAddr;
    logic [RW-1:0] reqData;
    logic          rspValid;
    logic [RW-1:0] rspData;
    logic          rspError;
    logic          busy;
    logic [1:0]    memCntrl;
    logic [AW-1:0] memAddr;
    logic [RW-1:0] memDataIn;
    logic          memIsIndirect;
    logic [RW-1:0] memDataOut;
    logic          memDataReady;

    mem_request_sequencer #(
        .ramWidth      (RW),
        .addrSize      (AW),
        .fifoDepth     (DEPTH),
        .timeoutCycles (TMO)
    ) dut (
        .clk           (clk),
        .clrN          (clrN),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqWrite      (reqWrite),
        .reqIndirect   (reqIndirect),
        .reqAddr       (reqAddr),
        .reqData       (reqData),
        .rspValid      (rspValid),
        .rspData       (rspData),
        .rspError      (rspError),
        .busy          (busy),
        .memCntrl      (memCntrl),
        .memAddr       (memAddr),
        .memDataIn     (memDataIn),
        .memIsIndirect (memIsIndirect),
        .memDataOut    (memDataOut),
        .memDataReady  (memDataReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          ind;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        int            acc;
    } req_t;

    req_t tx_q[$];     // requests waiting to be offered on reqValid
    req_t pend_q[$];   // model of the request FIFO contents
    req_t cur;         // request the model believes is in flight

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit drv_clrN = 1'b0;
    bit model_on = 1'b0;
    bit inflight = 1'b0;
    int t_iss, w_done, l_resp, idle_from, rdy_start, rdy_end;
    bit            exp_err;
    logic [RW-1:0] exp_data;

    // scripted memory behaviour
    bit            use_forced = 1'b0;
    int            f_delay    = 0;
    int            f_hold     = 0;
    bit            use_fdata  = 1'b0;
    logic [RW-1:0] f_data     = '0;

    // observations of the DUT used by the scenario-level checks
    int            rsp_seen   = 0;
    int            err_seen   = 0;
    int            issues     = 0;
    int            rd_cycles  = 0;
    int            obs_issue  = 0;
    int            obs_rsp    = 0;
    bit            saw_full   = 1'b0;
    logic [1:0]    prev_cntrl = 2'b00;
    logic [RW-1:0] last_rdata = '0;
    logic          last_rerr  = 1'b0;

    function automatic bit ready_at(input int c);
        return inflight && (c >= rdy_start) && (c <= rdy_end);
    endfunction

    // One model step for the current cycle: predict, compare, then advance
    task automatic model_cycle();
        int         c;
        int         d;
        int         h;
        logic [1:0] exp_cntrl;
        bit         exp_valid;
        bit         exp_rdy;
        bit         exp_busy;
        req_t       r;
        c = cyc;
        // The FIFO head is popped in an IDLE cycle no earlier than one cycle
        // after it was accepted; it appears on memCntrl the cycle after.
        if (!inflight && pend_q.size() > 0 && (c - 1) >= idle_from &&
            (c - 1) >= pend_q[0].acc + 1) begin
            cur      = pend_q.pop_front();
            inflight = 1'b1;
            t_iss    = c;
            issues++;
            if (use_forced) begin
                d = f_delay;
                h = f_hold;
            end else begin
                d = ($urandom_range(0, 7) == 7) ? NEVER : int'($urandom_range(0, 6));
                h = int'($urandom_range(0, 4));
            end
            rdy_start = c + 1 + d;
            rdy_end   = rdy_start + h;
            if (d <= TMO) begin
                w_done  = c + 1 + d;
                exp_err = 1'b0;
            end else begin
                w_done   = c + 1 + TMO;
                exp_err  = 1'b1;
                exp_data = '0;
            end
            l_resp    = w_done + 1;
            idle_from = NEVER;
        end
        if (inflight && c == w_done && !exp_err) exp_data = memDataOut;

        exp_cntrl = (inflight && c >= t_iss && c <= w_done) ?
                    (cur.wr ? 2'b10 : 2'b01) : 2'b00;
        exp_valid = inflight && (c == l_resp);
        exp_rdy   = (pend_q.size() < DEPTH);
        exp_busy  = (pend_q.size() > 0) || inflight;

        checks++;
        if (memCntrl !== exp_cntrl) begin
            failures++;
            $display("FAIL memCntrl cyc=%0d got=%0h exp=%0h", c, memCntrl, exp_cntrl);
        end
        if (exp_cntrl != 2'b00) begin
            checks++;
            if (memAddr !== cur.addr || memDataIn !== cur.data || memIsIndirect !== cur.ind) begin
                failures++;
                $display("FAIL mem_fields cyc=%0d got=%0h/%0h/%0b exp=%0h/%0h/%0b",
                         c, memAddr, memDataIn, memIsIndirect, cur.addr, cur.data, cur.ind);
            end
        end
        checks++;
        if (rspValid !== exp_valid) begin
            failures++;
            $display("FAIL rspValid cyc=%0d got=%0b exp=%0b", c, rspValid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (rspData !== exp_data || rspError !== exp_err) begin
                failures++;
                $display("FAIL rsp_payload cyc=%0d got=%0h/%0b exp=%0h/%0b",
                         c, rspData, rspError, exp_data, exp_err);
            end
        end
        checks++;
        if (reqReady !== exp_rdy) begin
            failures++;
            $display("FAIL reqReady cyc=%0d got=%0b exp=%0b", c, reqReady, exp_rdy);
        end
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%0b exp=%0b", c, busy, exp_busy);
        end

        // observations
        if (memCntrl !== 2'b00 && prev_cntrl === 2'b00) obs_issue = c;
        if (memCntrl === 2'b01) rd_cycles++;
        prev_cntrl = memCntrl;
        if (rspValid === 1'b1) begin
            rsp_seen++;
            obs_rsp    = c;
            last_rdata = rspData;
            last_rerr  = rspError;
            if (rspError === 1'b1) err_seen++;
        end
        if (reqReady === 1'b0) saw_full = 1'b1;

        // leave DRAIN on the first cycle after RESP with ready low
        if (inflight && c > l_resp && !memDataReady) begin
            idle_from = c + 1;
            inflight  = 1'b0;
        end
        if (reqValid && exp_rdy) begin
            r     = tx_q.pop_front();
            r.acc = c;
            pend_q.push_back(r);
        end
    endtask

    // Advance one clock: drive inputs after the edge, check at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        clrN = drv_clrN;
        if (tx_q.size() > 0) begin
            reqValid    = 1'b1;
            reqWrite    = tx_q[0].wr;
            reqIndirect = tx_q[0].ind;
            reqAddr     = tx_q[0].addr;
            reqData     = tx_q[0].data;
        end else begin
            reqValid    = 1'b0;
            reqWrite    = 1'($urandom);
            reqIndirect = 1'($urandom);
            reqAddr     = AW'($urandom);
            reqData     = RW'($urandom);
        end
        memDataReady = ready_at(cyc);
        memDataOut   = use_fdata ? f_data : RW'($urandom);
        @(negedge clk);
        if (model_on) model_cycle();
    endtask

    task automatic push_req(input logic wr, input logic ind,
                            input logic [AW-1:0] addr, input logic [RW-1:0] data);
        req_t r;
        r.wr = wr; r.ind = ind; r.addr = addr; r.data = data; r.acc = 0;
        tx_q.push_back(r);
    endtask

    task automatic release_reset();
        pend_q.delete();
        inflight   = 1'b0;
        idle_from  = cyc + 1;
        prev_cntrl = 2'b00;
        drv_clrN   = 1'b1;
        model_on   = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((tx_q.size() > 0 || pend_q.size() > 0 || inflight) && n < budget) begin
            tick();
            n++;
        end
        if (tx_q.size() > 0 || pend_q.size() > 0 || inflight) begin
            checks++;
            failures++;
            $display("FAIL %s_bound cyc=%0d got=pending exp=idle within %0d cycles", name, cyc, budget);
        end
        tick();
    endtask

    task automatic test_reset();
        drv_clrN = 1'b0;
        model_on = 1'b0;
        repeat (3) tick();
        checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0 || rspError !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=rdy%0b val%0b err%0b busy%0b exp=rdy1 val0 err0 busy0",
                     reqReady, rspValid, rspError, busy);
        end
        checks++;
        if (rspData !== '0) begin
            failures++;
            $display("FAIL reset_rspData got=%0h exp=0", rspData);
        end
        checks++;
        if (memCntrl !== 2'b00 || memAddr !== '0 || memDataIn !== '0 || memIsIndirect !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem got=%0h/%0h/%0h/%0b exp=0/0/0/0",
                     memCntrl, memAddr, memDataIn, memIsIndirect);
        end
        release_reset();
        repeat (2) tick();
    endtask

    task automatic test_single_load();
        int r0;
        int rd0;
        r0 = rsp_seen; rd0 = rd_cycles;
        use_forced = 1'b1; f_delay = 1; f_hold = 0;
        use_fdata  = 1'b1; f_data  = 8'hA5;
        push_req(1'b0, 1'b0, 8'h12, 8'h00);
        wait_idle("single_load", 40);
        use_fdata = 1'b0;
        checks++;
        if (rsp_seen - r0 !== 1) begin
            failures++;
            $display("FAIL load_rsp_count got=%0d exp=1", rsp_seen - r0);
        end
        checks++;
        if (last_rdata !== 8'hA5 || last_rerr !== 1'b0) begin
            failures++;
            $display("FAIL load_rsp_data got=%0h/%0b exp=a5/0", last_rdata, last_rerr);
        end
        checks++;
        if (rd_cycles - rd0 !== 3) begin
            failures++;
            $display("FAIL load_cntrl_cycles got=%0d exp=3", rd_cycles - rd0);
        end
    endtask

    task automatic test_store_indirect();
        int r0;
        r0 = rsp_seen;
        use_forced = 1'b1; f_delay = 2; f_hold = 1;
        push_req(1'b1, 1'b1, 8'h40, 8'h3C);
        wait_idle("store", 40);
        checks++;
        if (rsp_seen - r0 !== 1) begin
            failures++;
            $display("FAIL store_rsp_count got=%0d exp=1", rsp_seen - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int i0;
        r0 = rsp_seen; i0 = issues; saw_full = 1'b0;
        use_forced = 1'b1; f_delay = 3; f_hold = 0;
        push_req(1'b0, 1'b0, 8'h01, 8'h11);
        push_req(1'b1, 1'b0, 8'h02, 8'h22);
        push_req(1'b0, 1'b1, 8'h03, 8'h33);
        wait_idle("back_to_back", 80);
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_backpressure got=reqReady never low exp=low while full");
        end
        checks++;
        if (rsp_seen - r0 !== 3 || issues - i0 !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d rsp exp=3", rsp_seen - r0);
        end
    endtask

    task automatic test_timeout();
        int r0;
        int e0;
        int lat;
        r0 = rsp_seen; e0 = err_seen;
        use_forced = 1'b1; f_delay = NEVER; f_hold = 0;
        push_req(1'b0, 1'b0, 8'h77, 8'h00);
        wait_idle("timeout", 40);
        lat = obs_rsp - obs_issue;
        checks++;
        if (err_seen - e0 !== 1 || lat !== TMO + 2) begin
            failures++;
            $display("FAIL timeout_abort got=err%0d lat%0d exp=err1 lat%0d", err_seen - e0, lat, TMO + 2);
        end
        f_delay = 0;
        push_req(1'b1, 1'b0, 8'h78, 8'h9A);
        wait_idle("after_timeout", 40);
        checks++;
        if (rsp_seen - r0 !== 2 || err_seen - e0 !== 1) begin
            failures++;
            $display("FAIL after_timeout got=rsp%0d err%0d exp=rsp2 err1", rsp_seen - r0, err_seen - e0);
        end
    endtask

    task automatic test_drain_hold();
        int r0;
        r0 = rsp_seen;
        use_forced = 1'b1; f_delay = 1; f_hold = 4;
        push_req(1'b0, 1'b0, 8'hC0, 8'h00);
        push_req(1'b1, 1'b1, 8'hC1, 8'h5A);
        wait_idle("drain_hold", 60);
        checks++;
        if (rsp_seen - r0 !== 2) begin
            failures++;
            $display("FAIL drain_rsp_count got=%0d exp=2", rsp_seen - r0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int r0;
        use_forced = 1'b1; f_delay = NEVER; f_hold = 0;
        push_req(1'b0, 1'b0, 8'hE0, 8'h00);
        push_req(1'b1, 1'b0, 8'hE1, 8'h01);
        push_req(1'b0, 1'b1, 8'hE2, 8'h02);
        n = 0;
        while (!(inflight && cyc > t_iss && pend_q.size() == 2) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!(inflight && pend_q.size() == 2)) begin
            failures++;
            $display("FAIL midwait_setup got=queue %0d exp=2 queued in WAIT", pend_q.size());
        end
        r0 = rsp_seen;
        @(posedge clk);
        #3;
        clrN = 1'b0;
        #1;
        checks++;
        if (memCntrl !== 2'b00 || rspValid !== 1'b0 || busy !== 1'b0 || reqReady !== 1'b1) begin
            failures++;
            $display("FAIL midwait_async got=cntrl%0h val%0b busy%0b rdy%0b exp=cntrl0 val0 busy0 rdy1",
                     memCntrl, rspValid, busy, reqReady);
        end
        drv_clrN = 1'b0;
        model_on = 1'b0;
        inflight = 1'b0;
        tx_q.delete();
        pend_q.delete();
        repeat (2) tick();
        release_reset();
        repeat (6) tick();
        checks++;
        if (rsp_seen - r0 !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midwait_discard got=rsp%0d busy%0b exp=rsp0 busy0", rsp_seen - r0, busy);
        end
    endtask

    task automatic test_random();
        int r0;
        int i0;
        r0 = rsp_seen; i0 = issues;
        use_forced = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (tx_q.size() < 2 && $urandom_range(0, 2) == 0)
                push_req(1'($urandom), 1'($urandom), AW'($urandom), RW'($urandom));
            tick();
        end
        wait_idle("random", 200);
        checks++;
        if (rsp_seen - r0 !== issues - i0) begin
            failures++;
            $display("FAIL random_rsp_count got=%0d exp=%0d", rsp_seen - r0, issues - i0);
        end
    endtask

    initial begin
        clrN         = 1'b0;
        reqValid     = 1'b0;
        reqWrite     = 1'b0;
        reqIndirect  = 1'b0;
        reqAddr      = '0;
        reqData      = '0;
        memDataOut   = '0;
        memDataReady = 1'b0;
        test_reset();
        test_single_load();
        test_store_indirect();
        test_back_to_back();
        test_timeout();
        test_drain_hold();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_request_sequencer

`default_nettype wire
